// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit and receive blocks.
// Slot geometry is fixed at 64fs (two 32-bit slots per frame).
package i2s_pkg;

    typedef logic [1:0] i2s_state_t;

    localparam i2s_state_t UNSYNC = 2'd0;
    localparam i2s_state_t LEFT   = 2'd1;
    localparam i2s_state_t RIGHT  = 2'd2;

    localparam int SLOT_BITS = 32;

endpackage

// File: rtl/i2s_rx_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level into the clk domain.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises stereo frames from ADC data using the bit/word clock
// levels seen in the clk domain and hands completed frames out with valid/ready.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                valid,
    input  logic                ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int CW = $clog2(AUDIO_DW + 1);

    logic                sdata_s;
    logic                sclk_d_q, lr_prev_q, lr_seen_q;
    logic                rise, lr_chg, capture, publish;
    i2s_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [AUDIO_DW-1:0] shl_q, shl_d, shr_q, shr_d;
    logic [AUDIO_DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [AUDIO_DW-1:0] cur_sh, shifted, aligned;
    logic [AUDIO_DW-1:0] left_q, left_d, right_q, right_d;
    logic                valid_q, valid_d, overrun_q, overrun_d, pub_q;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sdata_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sdata),
        .q_o   (sdata_s)
    );

    assign rise    = sclk & ~sclk_d_q;
    assign lr_chg  = rise & (lrclk != lr_prev_q);
    assign capture = rise && (state_q != UNSYNC);

    // lr_seen_q keeps the reset value of lr_prev from counting as an observed
    // word-clock level, so a reset mid left slot cannot sync on a partial slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_d_q  <= 1'b1;
            lr_prev_q <= 1'b1;
            lr_seen_q <= 1'b0;
        end else begin
            sclk_d_q <= sclk;
            if (rise) begin
                lr_prev_q <= lrclk;
                lr_seen_q <= 1'b1;
            end
        end
    end

    // The sampled bit belongs to the slot of lr_prev; short slots are left-aligned on close.
    always_comb begin
        cur_sh  = lr_prev_q ? shr_q : shl_q;
        shifted = cur_sh;
        cnt_inc = cnt_q;
        if (cnt_q < CW'(AUDIO_DW)) begin
            shifted = (cur_sh << 1) | AUDIO_DW'(sdata_s);
            cnt_inc = cnt_q + 1'b1;
        end
        aligned = shifted << (CW'(AUDIO_DW) - cnt_inc);
    end

    always_comb begin
        cnt_d    = cnt_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (capture) begin
            cnt_d = cnt_inc;
            if (lr_prev_q) shr_d = shifted;
            else           shl_d = shifted;
            if (lr_chg) begin
                cnt_d = '0;
                if (lr_prev_q) begin
                    hold_r_d = aligned;
                    shr_d    = '0;
                end else begin
                    hold_l_d = aligned;
                    shl_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            shl_q    <= '0;
            shr_q    <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= UNSYNC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNSYNC:  if (lr_chg && lr_seen_q && !lrclk) state_d = LEFT;
            LEFT:    if (lr_chg && lrclk)               state_d = RIGHT;
            RIGHT:   if (lr_chg && !lrclk)              state_d = LEFT;
            default:                                    state_d = UNSYNC;
        endcase
    end

    always_comb begin
        publish = (state_q == RIGHT) && lr_chg && !lrclk;
    end

    // Set beats clear for overrun; a publish beats the accept for valid.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (pub_q) begin
            if (!valid_q || ready) begin
                left_d  = hold_l_q;
                right_d = hold_r_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pub_q     <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pub_q     <= publish;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign left_chan  = left_q;
    assign right_chan = right_q;
    assign valid      = valid_q;
    assign overrun    = overrun_q;

endmodule
